// File: rtl/dfi_timing_ctrl_if.sv
// DFI data-path timing bundle: configuration, per-phase enables in, timed enables out.
interface dfi_timing_ctrl_if #(
  parameter int NPHASES = 2
);
  logic [3:0]         cfg_wrlat;
  logic [3:0]         cfg_rdlat;
  logic [NPHASES-1:0] dfi_wrdata_en;
  logic [NPHASES-1:0] dfi_rddata_en;
  logic               err_clr;
  logic [NPHASES-1:0] dq_oe;
  logic               dqs_oe;
  logic [NPHASES-1:0] dfi_rddata_valid;
  logic               busy;
  logic [3:0]         act_wrlat;
  logic [3:0]         act_rdlat;
  logic               err_turnaround;

  modport master (
    output cfg_wrlat, cfg_rdlat, dfi_wrdata_en, dfi_rddata_en, err_clr,
    input  dq_oe, dqs_oe, dfi_rddata_valid, busy, act_wrlat, act_rdlat, err_turnaround
  );

  modport slave (
    input  cfg_wrlat, cfg_rdlat, dfi_wrdata_en, dfi_rddata_en, err_clr,
    output dq_oe, dqs_oe, dfi_rddata_valid, busy, act_wrlat, act_rdlat, err_turnaround
  );
endinterface

// File: rtl/dfi_timing_ctrl.sv
// Delays DFI write/read data enables by programmable latencies, generates DQS
// preamble/postamble, and flags write/read bus turnaround conflicts.
module dfi_timing_ctrl #(
  parameter int NPHASES   = 2,
  parameter int MAX_LAT   = 8,
  parameter int WRLAT_RST = 2,
  parameter int RDLAT_RST = 5
) (
  input logic              sys_clk,
  input logic              sys_rst,
  dfi_timing_ctrl_if.slave bus
);
  localparam logic [3:0] WR_HI = 4'(MAX_LAT - 1);
  localparam logic [3:0] RD_HI = 4'(MAX_LAT);

  function automatic logic [3:0] clamp_lat(input logic [3:0] v, input logic [3:0] hi);
    if (v == 4'd0) return 4'd1;
    if (v > hi) return hi;
    return v;
  endfunction

  localparam logic [3:0] WR_RST = clamp_lat(4'(WRLAT_RST), WR_HI);
  localparam logic [3:0] RD_RST = clamp_lat(4'(RDLAT_RST), RD_HI);

  logic [NPHASES-1:0] wr_line [MAX_LAT+1];
  logic [NPHASES-1:0] rd_line [MAX_LAT+1];
  logic [NPHASES-1:0] dq_oe_q, rv_q;
  logic               dqs_q, busy_q, err_q;
  logic [3:0]         act_wr, act_rd;

  logic [NPHASES-1:0] dq_next, wr_pre, rv_next;
  logic               dqs_next, pend, adopt, err_set;

  // Entry k of a line holds the enable sampled k+1 cycles ago; the output
  // register adds the final cycle, so a latency L taps entry L-2.
  always_comb begin
    dq_next = '0;
    wr_pre  = '0;
    rv_next = '0;
    pend    = (|bus.dfi_wrdata_en) || (|bus.dfi_rddata_en);
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (k + 2 == int'(act_wr)) dq_next = wr_line[k];
      if (k + 3 == int'(act_wr)) wr_pre  = wr_line[k];
      if (k + 2 == int'(act_rd)) rv_next = rd_line[k];
      if (k + 3 <= int'(act_wr) && wr_line[k] != '0) pend = 1'b1;
      if (k + 3 <= int'(act_rd) && rd_line[k] != '0) pend = 1'b1;
    end
    if (act_wr == 4'd1) dq_next = bus.dfi_wrdata_en;
    if (act_wr == 4'd2) wr_pre  = bus.dfi_wrdata_en;
    if (act_rd == 4'd1) rv_next = bus.dfi_rddata_en;
    // At latency 1 the preamble would need next cycle's input, so it is absent.
    dqs_next = (|dq_oe_q) || (|dq_next) || (|wr_pre);
    pend     = pend || (|dq_next) || dqs_next || (|rv_next);
    adopt    = !busy_q && (bus.dfi_wrdata_en == '0) && (bus.dfi_rddata_en == '0);
    err_set  = ((|bus.dfi_wrdata_en) && (|bus.dfi_rddata_en)) || ((|dq_oe_q) && (|rv_q));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        wr_line[k] <= '0;
        rd_line[k] <= '0;
      end
      dq_oe_q <= '0;
      rv_q    <= '0;
      dqs_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      act_wr  <= WR_RST;
      act_rd  <= RD_RST;
    end else begin
      wr_line[0] <= bus.dfi_wrdata_en;
      rd_line[0] <= bus.dfi_rddata_en;
      // Clearing on adoption drops stale entries beyond the old latency.
      for (int k = 1; k <= MAX_LAT; k++) begin
        wr_line[k] <= adopt ? '0 : wr_line[k-1];
        rd_line[k] <= adopt ? '0 : rd_line[k-1];
      end
      if (adopt) begin
        act_wr <= clamp_lat(bus.cfg_wrlat, WR_HI);
        act_rd <= clamp_lat(bus.cfg_rdlat, RD_HI);
      end
      dq_oe_q <= dq_next;
      rv_q    <= rv_next;
      dqs_q   <= dqs_next;
      busy_q  <= pend;
      err_q   <= err_set || (err_q && !bus.err_clr);
    end
  end

  assign bus.dq_oe            = dq_oe_q;
  assign bus.dqs_oe           = dqs_q;
  assign bus.dfi_rddata_valid = rv_q;
  assign bus.busy             = busy_q;
  assign bus.act_wrlat        = act_wr;
  assign bus.act_rdlat        = act_rd;
  assign bus.err_turnaround   = err_q;
endmodule

// File: doc/dfi_timing_ctrl.md
DFI_TIMING_CTRL -- requirements
Module: dfi_timing_ctrl

Interface
REQ-001 SHALL take parameter NPHASES, default 2, DFI phases per sys_clk cycle, legal 1..4.
REQ-002 SHALL take parameter MAX_LAT, default 8, longest supported latency in sys_clk cycles, legal 2..15.
REQ-003 SHALL take parameter WRLAT_RST, default 2, write latency loaded at reset.
REQ-004 SHALL take parameter RDLAT_RST, default 5, read latency loaded at reset.
REQ-005 SHALL have port sys_clk, input, 1, the only clock; all logic is rising-edge.
REQ-006 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_wrlat, input, 4, requested write latency.
REQ-008 SHALL have port cfg_rdlat, input, 4, requested read latency.
REQ-009 SHALL have port dfi_wrdata_en, input, NPHASES, per-phase write-data enable, bit i = phase i.
REQ-010 SHALL have port dfi_rddata_en, input, NPHASES, per-phase read-data enable.
REQ-011 SHALL have port err_clr, input, 1, clears err_turnaround.
REQ-012 SHALL have port dq_oe, output, NPHASES, per-phase DQ/DM output enable.
REQ-013 SHALL have port dqs_oe, output, 1, DQS output enable including preamble/postamble.
REQ-014 SHALL have port dfi_rddata_valid, output, NPHASES, per-phase read-data valid.
REQ-015 SHALL have port busy, output, 1, any enable in flight.
REQ-016 SHALL have port act_wrlat, output, 4, write latency in force.
REQ-017 SHALL have port act_rdlat, output, 4, read latency in force.
REQ-018 SHALL have port err_turnaround, output, 1, sticky bus-conflict flag.

Function
REQ-019 Write and read enables SHALL each enter a shift register MAX_LAT+1 entries deep, NPHASES bits wide, advancing one entry per sys_clk.
REQ-020 dq_oe SHALL equal, bitwise, the dfi_wrdata_en vector sampled exactly act_wrlat cycles earlier; phase order preserved.
REQ-021 dqs_oe SHALL be high in cycle t if any dq_oe bit is high in t-1, t or t+1 (one-cycle preamble and postamble); back-to-back writes SHALL give a continuous dqs_oe with no gap.
REQ-022 dfi_rddata_valid SHALL equal, bitwise, the dfi_rddata_en vector sampled exactly act_rdlat cycles earlier.
REQ-023 Clamping: cfg_wrlat SHALL be clamped to 1..MAX_LAT-1; cfg_rdlat to 1..MAX_LAT; act_* report the clamped value.
REQ-024 Config adoption: act_wrlat/act_rdlat SHALL load clamped cfg_* only in a cycle where busy=0 and both enable inputs are all-zero; otherwise held, so no in-flight burst is retimed.
REQ-025 busy SHALL be high while any delay-line entry is nonzero or any dqs_oe postamble is pending.
REQ-026 err_turnaround SHALL set when, in one cycle, (any dfi_wrdata_en bit and any dfi_rddata_en bit are high) or (any dq_oe bit and any dfi_rddata_valid bit are high).
REQ-027 err_turnaround SHALL stay set until err_clr; a simultaneous set and clear SHALL leave it set.
REQ-028 Enables SHALL still propagate normally when err_turnaround is set; the flag is report-only.
REQ-029 Outputs dq_oe, dqs_oe, dfi_rddata_valid, busy, err_turnaround SHALL be registered (no combinational path from inputs).

Reset
REQ-030 On sys_rst=1 at a clock edge: delay lines cleared, dq_oe=0, dqs_oe=0, dfi_rddata_valid=0, busy=0, err_turnaround=0, act_wrlat=WRLAT_RST, act_rdlat=RDLAT_RST (clamped).
REQ-031 Reset mid-burst SHALL discard all in-flight enables; no dq_oe or dfi_rddata_valid pulse SHALL appear after reset deasserts from pre-reset traffic.
REQ-032 Enables presented while sys_rst=1 SHALL be ignored.

Verification (NPHASES=2, MAX_LAT=8, defaults)
REQ-033 Write: dfi_wrdata_en=2'b10 at cycle 10 -> dq_oe=2'b10 at cycle 12 only; dqs_oe high cycles 11-13; busy low from cycle 14.
REQ-034 Read: dfi_rddata_en=2'b01 at cycle 10 -> dfi_rddata_valid=2'b01 at cycle 15 only; err_turnaround stays 0.
REQ-035 Back-to-back writes at cycles 10,11,12 -> dq_oe high 12-14, dqs_oe continuous 11-15.
REQ-036 Config: cfg_rdlat=3 while read in flight -> act_rdlat stays 5 until idle, then 3; next read at t returns at t+3; cfg_wrlat=0 -> act_wrlat=1; cfg_rdlat=12 -> act_rdlat=8.
REQ-037 Conflict: write at cycle 10, read at cycle 7 (both land cycle 12) -> err_turnaround set at 13, held until err_clr pulse; both outputs still pulse at 12.
REQ-038 Reset: read at cycle 10, sys_rst at cycle 12 -> no dfi_rddata_valid through cycle 20; act_* return to 2/5.
